mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single combined instruction/data memory between the multicycle CPU core and a host loader/debug port.
- Grants exactly one owner per cycle and drives the memory address, data and strobes for that owner.
- Stalls the CPU when the host owns the port, and provides a halt handshake that freezes the CPU at an instruction-fetch boundary.
- Sits between the CPU top level (memory address mux, MemRead/MemWrite, PC/state-advance enables) and the memory instance.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- HOST_MAX_WAIT, 4, maximum consecutive cycles a pending host request is deferred before it takes priority. Range 1..15.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- cpu_rd, in, 1, CPU memory read request (MemRead).
- cpu_wr, in, 1, CPU memory write request (MemWrite).
- cpu_addr, in, ADDR_W, CPU address (PC or ALU_out after the IorD mux).
- cpu_wdata, in, DATA_W, CPU store data (B register).
- cpu_fetch, in, 1, CPU is in its instruction-fetch state this cycle (instruction boundary).
- cpu_stall, out, 1, CPU must hold all state, PC and IR this cycle.
- host_req, in, 1, host access request; held until host_gnt.
- host_we, in, 1, host access is a write.
- host_addr, in, ADDR_W, host address.
- host_wdata, in, DATA_W, host write data.
- host_gnt, out, 1, registered one-cycle pulse: host access completed in the previous cycle.
- host_rdata, out, DATA_W, registered read data, valid while host_gnt=1, held afterwards.
- host_halt_req, in, 1, level request to freeze the CPU.
- host_halt_ack, out, 1, CPU is frozen at a fetch boundary.
- mem_addr, out, ADDR_W, address to memory (combinational mux).
- mem_wdata, out, DATA_W, write data to memory (combinational mux).
- mem_rd, out, 1, read strobe to memory.
- mem_wr, out, 1, write strobe to memory.
- mem_rdata, in, DATA_W, combinational read data from memory.
- stall_cnt, out, STALL_CNT_W, saturating count of cycles with cpu_stall=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State RUN.
  - wait_cnt=0, host_gnt=0, host_rdata=0, host_halt_ack=0, stall_cnt=0.
  - Any in-flight host access is dropped; no host_gnt is issued for it.
  - Combinational outputs follow the state: CPU owns the port.
- States:
  - RUN: CPU has priority.
  - HALT_PEND: waiting for a fetch boundary.
  - HALTED: CPU frozen; host owns the port.
- Definitions:
  - cpu_act = cpu_rd | cpu_wr.
  - host_ok = host_req & ~host_gnt. This inserts one bubble after every grant, so host_req held on the gnt cycle is not re-served.
- Owner, combinational:
  - HOST if state==HALTED & host_ok.
  - HOST if state in {RUN, HALT_PEND} & host_ok & (~cpu_act | wait_cnt==HOST_MAX_WAIT).
  - Otherwise CPU.
- Memory drive:
  - Owner CPU: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_rd=cpu_rd & ~cpu_wr, mem_wr=cpu_wr. In HALTED both strobes are forced to 0.
  - Owner HOST: mem_addr=host_addr, mem_wdata=host_wdata, mem_wr=host_we, mem_rd=~host_we.
  - cpu_rd and cpu_wr both high: write wins and mem_rd=0.
- cpu_stall = (owner==HOST & cpu_act) | state==HALTED | (state==HALT_PEND & cpu_fetch).
- wait_cnt:
  - Cleared when owner==HOST or host_req=0.
  - Otherwise, when host_ok & owner==CPU, increments and saturates at HOST_MAX_WAIT.
- Host completion:
  - On the edge ending a host-owned cycle: host_gnt<=1, and host_rdata<=mem_rdata if host_we=0.
  - Otherwise host_gnt<=0.
  - Write latency is 1 edge; read data is visible the cycle after service.
- Halt FSM:
  - RUN→HALT_PEND when host_halt_req=1.
  - HALT_PEND→HALTED on the edge of a cycle with cpu_fetch=1 (that fetch is stalled and not performed).
  - HALT_PEND→RUN if host_halt_req drops first.
  - HALTED→RUN when host_halt_req=0.
  - host_halt_ack = registered (state==HALTED).
  - After release the CPU resumes with the same fetch.
- stall_cnt increments on each edge where cpu_stall=1 and saturates at all ones.
- Simultaneous host_req and halt entry: the host is served per the owner rule in the same cycle.

Decomposition:
- Shared package: state encoding (RUN=2'd0, HALT_PEND=2'd1, HALTED=2'd2) and the owner enum (OWN_CPU, OWN_HOST).
- No sub-module is needed; a single module with a combinational owner/mux block and a registered FSM/counter block.

Test Plan:
- CPU-only traffic: cpu_rd=1 at addr 0x0000_0010, host idle → mem_addr=0x10, mem_rd=1, cpu_stall=0 every cycle, stall_cnt=0.
- Host read while CPU is idle: host_req=1, host_we=0, addr 0x40, mem_rdata=0xDEAD_BEEF → host_gnt pulses the next cycle with host_rdata=0xDEADBEEF, cpu_stall=0.
- Starvation bound: CPU active every cycle, host write 0x55 to 0x80 → host served on the 5th cycle (HOST_MAX_WAIT=4), cpu_stall=1 in that cycle only, mem_wr=1 with addr 0x80, stall_cnt=1.
- Halt handshake: host_halt_req=1 with cpu_fetch first high 3 cycles later → HALTED after that edge, host_halt_ack=1 one cycle later, cpu_stall=1 continuously. Dropping the request → RUN next cycle, ack=0.
- Back-to-back host requests while HALTED: host_req held high → grants at most every 2nd cycle; no double write to the same address.
- Reset mid-access: reset=0 while a host read is being served → host_gnt stays 0, all registers zero, state RUN; CPU owns the port after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU/host memory port arbiter: halt FSM encoding and port owner.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, host and memory-side signals of the shared memory port, bundled for the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_fetch;
  logic              cpu_stall;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_halt_req;
  logic              host_halt_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_fetch,
    input  host_req, host_we, host_addr, host_wdata, host_halt_req,
    input  mem_rdata,
    output cpu_stall, host_gnt, host_rdata, host_halt_ack,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_fetch,
    output host_req, host_we, host_addr, host_wdata, host_halt_req,
    output mem_rdata,
    input  cpu_stall, host_gnt, host_rdata, host_halt_ack,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single instruction/data memory between the multicycle CPU and a host
// loader/debug port, with bounded host wait and a fetch-boundary halt handshake.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_port_arbiter_if.slave      bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT = WAIT_CNT_W'(HOST_MAX_WAIT);

  arb_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   host_gnt_q, host_gnt_d;
  logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;
  logic                   halt_ack_q, halt_ack_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  owner_e            owner;
  logic              cpu_act;
  logic              host_ok;
  logic              cpu_stall;
  logic [ADDR_W-1:0] addr_mux;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;
  // The just-granted request is still high on the gnt cycle; this keeps it from being re-served.
  assign host_ok = bus.host_req & ~host_gnt_q;

  always_comb begin
    owner = OWN_CPU;
    if (host_ok) begin
      if (state_q == ST_HALTED)
        owner = OWN_HOST;
      else if (!cpu_act || wait_cnt_q == MAX_WAIT)
        owner = OWN_HOST;
    end
  end

  always_comb begin
    addr_mux      = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
    bus.mem_wr    = bus.cpu_wr;
    if (owner == OWN_HOST) begin
      addr_mux      = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.mem_rd    = ~bus.host_we;
      bus.mem_wr    = bus.host_we;
    end else if (state_q == ST_HALTED) begin
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
    end
  end

  assign bus.mem_addr = addr_mux;

  assign cpu_stall = (owner == OWN_HOST && cpu_act) || state_q == ST_HALTED ||
                     (state_q == ST_HALT_PEND && bus.cpu_fetch);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:       if (bus.host_halt_req) state_d = ST_HALT_PEND;
      ST_HALT_PEND: begin
        if (!bus.host_halt_req)  state_d = ST_RUN;
        else if (bus.cpu_fetch)  state_d = ST_HALTED;
      end
      ST_HALTED:    if (!bus.host_halt_req) state_d = ST_RUN;
      default:      state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (owner == OWN_HOST || !bus.host_req)
      wait_cnt_d = '0;
    else if (host_ok && wait_cnt_q != MAX_WAIT)
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);

    host_gnt_d   = (owner == OWN_HOST);
    host_rdata_d = host_rdata_q;
    if (owner == OWN_HOST && !bus.host_we)
      host_rdata_d = bus.mem_rdata;

    halt_ack_d  = (state_q == ST_HALTED);
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= '0;
      host_gnt_q   <= 1'b0;
      host_rdata_q <= '0;
      halt_ack_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      host_gnt_q   <= host_gnt_d;
      host_rdata_q <= host_rdata_d;
      halt_ack_q   <= halt_ack_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.cpu_stall     = cpu_stall;
  assign bus.host_gnt      = host_gnt_q;
  assign bus.host_rdata    = host_rdata_q;
  assign bus.host_halt_ack = halt_ack_q;
  assign stall_cnt         = stall_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: CPU traffic, host service, wait bound, halt and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] stall_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .HOST_MAX_WAIT(4), .STALL_CNT_W(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset             = 1'b0;
    bus.cpu_rd        = 1'b0;
    bus.cpu_wr        = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_fetch     = 1'b0;
    bus.host_req      = 1'b0;
    bus.host_we       = 1'b0;
    bus.host_addr     = '0;
    bus.host_wdata    = '0;
    bus.host_halt_req = 1'b0;
    bus.mem_rdata     = '0;
    repeat (2) tick();

    check("rst_gnt",   bus.host_gnt, 0);
    check("rst_rdata", bus.host_rdata, 0);
    check("rst_ack",   bus.host_halt_ack, 0);
    check("rst_scnt",  stall_cnt, 0);
    check("rst_stall", bus.cpu_stall, 0);
    reset = 1'b1;

    // CPU-only traffic
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("cpu_addr",  bus.mem_addr, 32'h10);
      check("cpu_rd",    bus.mem_rd, 1);
      check("cpu_stall", bus.cpu_stall, 0);
      tick();
    end
    bus.cpu_wr    = 1'b1;
    bus.cpu_wdata = 32'hA5;
    settle();
    check("rdwr_rd",    bus.mem_rd, 0);
    check("rdwr_wr",    bus.mem_wr, 1);
    check("rdwr_wdata", bus.mem_wdata, 32'hA5);
    tick();
    check("cpu_scnt", stall_cnt, 0);

    // Host read with CPU idle
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 32'h40;
    bus.mem_rdata = 32'hDEAD_BEEF;
    settle();
    check("hrd_addr",  bus.mem_addr, 32'h40);
    check("hrd_rd",    bus.mem_rd, 1);
    check("hrd_wr",    bus.mem_wr, 0);
    check("hrd_stall", bus.cpu_stall, 0);
    tick();
    check("hrd_gnt",   bus.host_gnt, 1);
    check("hrd_rdata", bus.host_rdata, 32'hDEAD_BEEF);
    bus.host_req  = 1'b0;
    bus.mem_rdata = '0;
    settle();
    check("hrd_idle_rd", bus.mem_rd, 0);
    tick();
    check("hrd_gnt_off", bus.host_gnt, 0);
    check("hrd_hold",    bus.host_rdata, 32'hDEAD_BEEF);

    // Host write under continuous CPU traffic: deferred 4 cycles, served on the 5th
    bus.cpu_rd     = 1'b1;
    bus.cpu_addr   = 32'h10;
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h80;
    bus.host_wdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("wait_addr",  bus.mem_addr, 32'h10);
      check("wait_stall", bus.cpu_stall, 0);
      tick();
      check("wait_gnt",   bus.host_gnt, 0);
    end
    settle();
    check("starve_addr",  bus.mem_addr, 32'h80);
    check("starve_wr",    bus.mem_wr, 1);
    check("starve_rd",    bus.mem_rd, 0);
    check("starve_wdata", bus.mem_wdata, 32'h55);
    check("starve_stall", bus.cpu_stall, 1);
    tick();
    check("starve_gnt",  bus.host_gnt, 1);
    check("starve_scnt", stall_cnt, 1);
    bus.host_req = 1'b0;
    settle();
    check("starve_back_addr",  bus.mem_addr, 32'h10);
    check("starve_back_stall", bus.cpu_stall, 0);
    tick();

    // Halt request withdrawn before a fetch boundary
    bus.host_halt_req = 1'b1;
    bus.cpu_fetch     = 1'b0;
    settle();
    tick();
    bus.host_halt_req = 1'b0;
    bus.cpu_fetch     = 1'b1;
    settle();
    check("abort_pend_stall", bus.cpu_stall, 1);
    tick();
    settle();
    check("abort_run_stall", bus.cpu_stall, 0);
    check("abort_scnt",      stall_cnt, 2);

    // Halt handshake: fetch arrives 3 cycles after the request
    bus.host_halt_req = 1'b1;
    bus.cpu_fetch     = 1'b0;
    settle();
    check("halt_c0_stall", bus.cpu_stall, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("halt_pend_stall", bus.cpu_stall, 0);
      tick();
    end
    bus.cpu_fetch = 1'b1;
    settle();
    check("halt_fetch_stall", bus.cpu_stall, 1);
    tick();
    settle();
    check("halted_stall",  bus.cpu_stall, 1);
    check("halted_ack0",   bus.host_halt_ack, 0);
    check("halted_mem_rd", bus.mem_rd, 0);
    tick();
    settle();
    check("halted_ack1",   bus.host_halt_ack, 1);
    check("halted_stall2", bus.cpu_stall, 1);
    tick();

    // Back-to-back host writes while halted: served every other cycle
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 32'h90;
    bus.host_wdata = 32'h77;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("b2b_wr",    bus.mem_wr, (k % 2 == 0) ? 1 : 0);
      check("b2b_gnt",   bus.host_gnt, (k % 2 == 0) ? 0 : 1);
      check("b2b_stall", bus.cpu_stall, 1);
      tick();
    end
    bus.host_req = 1'b0;
    settle();
    check("b2b_gnt_end", bus.host_gnt, 0);
    bus.host_halt_req = 1'b0;
    settle();
    check("release_stall", bus.cpu_stall, 1);
    tick();
    settle();
    check("resume_stall", bus.cpu_stall, 0);
    check("resume_rd",    bus.mem_rd, 1);
    check("resume_ack",   bus.host_halt_ack, 1);
    check("resume_scnt",  stall_cnt, 10);
    tick();
    check("resume_ack0", bus.host_halt_ack, 0);

    // Asynchronous reset in the middle of a host read
    bus.cpu_rd    = 1'b0;
    bus.cpu_fetch = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 32'h44;
    bus.mem_rdata = 32'h1234_5678;
    settle();
    check("mid_addr", bus.mem_addr, 32'h44);
    check("mid_rd",   bus.mem_rd, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_gnt",   bus.host_gnt, 0);
    check("mid_rst_rdata", bus.host_rdata, 0);
    check("mid_rst_scnt",  stall_cnt, 0);
    check("mid_rst_ack",   bus.host_halt_ack, 0);
    bus.host_req = 1'b0;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h20;
    tick();
    check("mid_rst_gnt2", bus.host_gnt, 0);
    reset = 1'b1;
    settle();
    check("post_rst_addr",  bus.mem_addr, 32'h20);
    check("post_rst_rd",    bus.mem_rd, 1);
    check("post_rst_stall", bus.cpu_stall, 0);
    tick();
    check("post_rst_gnt", bus.host_gnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
